// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the memory-control hierarchy.
//
// Contents:
//   word_t       32-bit machine word
//   ramstate_t   RAM handshake state reported by the RAM model
//   arb_state_t  mem_arbiter FSM states (ARB, SERVE)
//   arb_src_t    registered grant: core index plus I/D class flag
//   is_done()    true when the RAM reports a completion (ACCESS or ERROR)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB   = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    // Wide enough for up to 16 cores; the arbiter only ever stores indices < CPUS.
    localparam int CORE_IDX_W = 4;
    typedef logic [CORE_IDX_W-1:0] core_idx_t;

    typedef struct packed {
        logic      is_d;   // 1 = dcache port, 0 = icache port
        core_idx_t core;
    } arb_src_t;

    function automatic logic is_done(input ramstate_t rs);
        return (rs == ACCESS) || (rs == ERROR);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin picker for one request class.
//
// Ports:
//   req    CPUS-wide request vector
//   last   index of the core granted last time in this class
//   gnt    one-hot grant: first requester strictly after 'last', wrapping
//   valid  at least one request present
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic      [CPUS-1:0] req,
    input  core_idx_t            last,
    output logic      [CPUS-1:0] gnt,
    output logic                 valid
);

    logic found;

    // Scan offsets 1..CPUS from the pointer; offset CPUS lands back on 'last'
    // itself, so a lone requester that was granted last time still wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        for (int off = 1; off <= CPUS; off++) begin
            for (int i = 0; i < CPUS; i++) begin
                if (!found && req[i] && (i == (int'(last) + off) % CPUS)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- memory-side responder for the cache_control_if protocol.
//
// Serialises icache fetches and dcache reads/writes from CPUS cores onto one
// single-ported RAM. dcache requests beat icache requests; each class is
// round-robin. A grant is held while the granted requester keeps its strobe
// up, so multi-word bursts run back to back with no ARB cycle between words.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iREN/iaddr          per-core icache request and word address
//   iwait/iload         per-core icache wait (low one cycle per word) and data
//   dREN/dWEN           per-core dcache read/write request
//   daddr/dstore        per-core dcache address and write data
//   dwait/dload         per-core dcache wait (low one cycle per word) and data
//   ramREN/ramWEN       RAM strobes (write wins if both requested)
//   ramaddr/ramstore    RAM address and write data
//   ramload/ramstate    RAM read data and handshake state
//   ram_err             one-cycle pulse on an ERROR completion
//
// Build option MEM_ARBITER_STATS_EN adds iwords/dwords (completed words per
// port, wrapping) and err_count (ERROR completions, saturating).
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    CPUS         = 2,
    parameter word_t RAM_ERR_WORD = 32'hBAD1BAD1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic      [CPUS-1:0]  iREN,
    input  word_t     [CPUS-1:0]  iaddr,
    output logic      [CPUS-1:0]  iwait,
    output word_t     [CPUS-1:0]  iload,
    input  logic      [CPUS-1:0]  dREN,
    input  logic      [CPUS-1:0]  dWEN,
    input  word_t     [CPUS-1:0]  daddr,
    input  word_t     [CPUS-1:0]  dstore,
    output logic      [CPUS-1:0]  dwait,
    output word_t     [CPUS-1:0]  dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output word_t                 ramaddr,
    output word_t                 ramstore,
    input  word_t                 ramload,
    input  ramstate_t             ramstate,
`ifdef MEM_ARBITER_STATS_EN
    output word_t     [CPUS-1:0]  iwords,
    output word_t     [CPUS-1:0]  dwords,
    output logic      [15:0]      err_count,
`endif
    output logic                  ram_err
);

    arb_state_t state_q, state_d;
    arb_src_t   grant_q, grant_d;
    core_idx_t  dptr_q, dptr_d;
    core_idx_t  iptr_q, iptr_d;

    logic [CPUS-1:0] d_req, d_gnt, i_gnt;
    logic            d_valid, i_valid;
    core_idx_t       d_idx, i_idx;

    logic  g_ren, g_wen;
    word_t g_addr, g_store, rd_word;

    assign d_req = dREN | dWEN;

    rr_pick #(.CPUS(CPUS)) u_pick_d (
        .req   (d_req),
        .last  (dptr_q),
        .gnt   (d_gnt),
        .valid (d_valid)
    );

    rr_pick #(.CPUS(CPUS)) u_pick_i (
        .req   (iREN),
        .last  (iptr_q),
        .gnt   (i_gnt),
        .valid (i_valid)
    );

    always_comb begin
        d_idx = '0;
        i_idx = '0;
        for (int i = 0; i < CPUS; i++) begin
            if (d_gnt[i]) d_idx = core_idx_t'(i);
            if (i_gnt[i]) i_idx = core_idx_t'(i);
        end
    end

    // Mux the granted port's request fields; icache ports never write.
    always_comb begin
        g_ren   = 1'b0;
        g_wen   = 1'b0;
        g_addr  = '0;
        g_store = '0;
        for (int i = 0; i < CPUS; i++) begin
            if (grant_q.core == core_idx_t'(i)) begin
                if (grant_q.is_d) begin
                    g_ren   = dREN[i];
                    g_wen   = dWEN[i];
                    g_addr  = daddr[i];
                    g_store = dstore[i];
                end else begin
                    g_ren  = iREN[i];
                    g_addr = iaddr[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (RST) begin
            state_q <= ARB;
            grant_q <= '0;
            dptr_q  <= '0;
            iptr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            dptr_q  <= dptr_d;
            iptr_q  <= iptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        dptr_d   = dptr_q;
        iptr_d   = iptr_q;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ram_err  = 1'b0;
        rd_word  = '0;

        unique case (state_q)
            ARB: begin
                if (d_valid) begin
                    grant_d = '{is_d: 1'b1, core: d_idx};
                    dptr_d  = d_idx;
                    state_d = SERVE;
                end else if (i_valid) begin
                    grant_d = '{is_d: 1'b0, core: i_idx};
                    iptr_d  = i_idx;
                    state_d = SERVE;
                end
            end

            SERVE: begin
                ramWEN   = g_wen;
                ramREN   = g_ren & ~g_wen;
                ramaddr  = g_addr;
                ramstore = g_store;

                // Completion is not gated by the strobe: a requester that
                // drops it in its completion cycle still gets the word.
                if (is_done(ramstate)) begin
                    ram_err = (ramstate == ERROR);
                    if (ramstate == ERROR) rd_word = RAM_ERR_WORD;
                    else if (!g_wen)       rd_word = ramload;
                    for (int i = 0; i < CPUS; i++) begin
                        if (grant_q.core == core_idx_t'(i)) begin
                            if (grant_q.is_d) begin
                                dwait[i] = 1'b0;
                                dload[i] = rd_word;
                            end else begin
                                iwait[i] = 1'b0;
                                iload[i] = rd_word;
                            end
                        end
                    end
                end

                // Lock: the grant persists while the requester holds a strobe.
                if (!(g_ren | g_wen)) state_d = ARB;
            end

            default: state_d = ARB;
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            iwords    <= '0;
            dwords    <= '0;
            err_count <= '0;
        end else if (state_q == SERVE && is_done(ramstate)) begin
            for (int i = 0; i < CPUS; i++) begin
                if (grant_q.core == core_idx_t'(i)) begin
                    if (grant_q.is_d) dwords[i] <= dwords[i] + 32'd1;
                    else              iwords[i] <= iwords[i] + 32'd1;
                end
            end
            if (ramstate == ERROR && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`else
    // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (CPUS = 2), table-driven per cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic            CLK = 1'b0;
    logic            RST;
    logic [1:0]      iREN, dREN, dWEN;
    word_t [1:0]     iaddr, daddr, dstore;
    logic [1:0]      iwait, dwait;
    word_t [1:0]     iload, dload;
    logic            ramREN, ramWEN, ram_err;
    word_t           ramaddr, ramstore, ramload;
    ramstate_t       ramstate;
`ifdef MEM_ARBITER_STATS_EN
    word_t [1:0]     iwords, dwords;
    logic [15:0]     err_count;
`endif

    mem_arbiter #(.CPUS(2), .RAM_ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
`ifdef MEM_ARBITER_STATS_EN
        .iwords   (iwords),
        .dwords   (dwords),
        .err_count(err_count),
`endif
        .ram_err  (ram_err)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // One record per clock cycle: inputs, then expected outputs.
    // e_wait = {iwait[1:0], dwait[1:0]}, e_str = {ramREN, ramWEN, ram_err},
    // e_dl = {dload[1], dload[0]}, e_il = {iload[1], iload[0]},
    // e_ec = expected err_count (stats build only), -1 = not checked.
    typedef struct {
        logic        rst;
        logic [1:0]  iren, dren, dwen;
        ramstate_t   rs;
        word_t       rload;
        logic [3:0]  e_wait;
        logic [2:0]  e_str;
        word_t       e_addr, e_store;
        logic [63:0] e_dl, e_il;
        int          e_ec;
    } vec_t;

    vec_t vecs[$];

    localparam word_t IA0 = 32'h200, IA1 = 32'h300;
    localparam word_t DA0 = 32'h40,  DA1 = 32'h140;
    localparam word_t DS0 = 32'hA5,  DS1 = 32'h5A;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] w, input logic [2:0] s,
                              input word_t a, input word_t st, input logic [63:0] dl,
                              input logic [63:0] il);
        check({tag, " waits"},  64'({iwait, dwait}), 64'(w));
        check({tag, " strobes"}, 64'({ramREN, ramWEN, ram_err}), 64'(s));
        check({tag, " ramaddr/store"}, {ramaddr, ramstore}, {a, st});
        check({tag, " dload"}, {dload[1], dload[0]}, dl);
        check({tag, " iload"}, {iload[1], iload[0]}, il);
    endtask

    task automatic add(input logic r, input logic [1:0] ir, input logic [1:0] dr,
                       input logic [1:0] dw, input ramstate_t rs, input word_t rl,
                       input logic [3:0] w, input logic [2:0] s, input word_t a,
                       input word_t st, input logic [63:0] dl, input logic [63:0] il,
                       input int ec);
        vec_t v;
        v = '{rst: r, iren: ir, dren: dr, dwen: dw, rs: rs, rload: rl, e_wait: w,
              e_str: s, e_addr: a, e_store: st, e_dl: dl, e_il: il, e_ec: ec};
        vecs.push_back(v);
    endtask

    initial begin
        RST = 1'b1; iREN = '0; dREN = '0; dWEN = '0;
        iaddr[0] = IA0; iaddr[1] = IA1;
        daddr[0] = DA0; daddr[1] = DA1;
        dstore[0] = DS0; dstore[1] = DS1;
        ramload = '0; ramstate = FREE;

        // ---- single dcache read, two BUSY cycles then ACCESS
        add(1, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, 0);  // reset state
        add(0, 2'b00, 2'b01, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1); // ARB
        add(0, 2'b00, 2'b01, 2'b00, BUSY,   32'h1234, 4'hF,    3'b100, DA0, DS0, 0, 0, -1);
        add(0, 2'b00, 2'b01, 2'b00, BUSY,   32'h1234, 4'hF,    3'b100, DA0, DS0, 0, 0, -1);
        add(0, 2'b00, 2'b01, 2'b00, ACCESS, 32'h1234, 4'b1110, 3'b100, DA0, DS0, 64'h1234, 0, -1);
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, DA0, DS0, 0, 0, -1); // release
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1); // ARB
        // ---- core0 icache vs core1 dcache: dcache first, drop at completion
        add(0, 2'b01, 2'b10, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1);
        add(0, 2'b01, 2'b00, 2'b00, ACCESS, 32'h5555, 4'b1101, 3'b000, DA1, DS1, {32'h5555, 32'h0}, 0, -1);
        add(0, 2'b01, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1); // one ARB
        add(0, 2'b01, 2'b00, 2'b00, BUSY,   0,        4'hF,    3'b100, IA0, 0,   0, 0, -1);
        add(0, 2'b01, 2'b00, 2'b00, ACCESS, 32'hCAFE, 4'b1011, 3'b100, IA0, 0,   0, 64'hCAFE, -1);
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, IA0, 0,   0, 0, -1);
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1);
        // ---- round robin from reset pointer: expect cores 1,0,1,0
        add(1, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1);
        for (int g = 0; g < 4; g++) begin
            bit    c1;
            word_t rl;
            c1 = (g % 2 == 0);
            rl = word_t'(32'h11 * (g + 1));
            add(0, 2'b00, 2'b11, 2'b00, FREE,   0,  4'hF, 3'b000, 0, 0, 0, 0, -1);
            add(0, 2'b00, 2'b11, 2'b00, ACCESS, rl, c1 ? 4'b1101 : 4'b1110, 3'b100,
                c1 ? DA1 : DA0, c1 ? DS1 : DS0, c1 ? {rl, 32'h0} : {32'h0, rl}, 0, -1);
            add(0, 2'b00, c1 ? 2'b01 : 2'b10, 2'b00, FREE, 0, 4'hF, 3'b000,
                c1 ? DA1 : DA0, c1 ? DS1 : DS0, 0, 0, -1);
        end
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1);
        // ---- ERROR completion on core1 dREN
        add(0, 2'b00, 2'b10, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, 0);
        add(0, 2'b00, 2'b10, 2'b00, ERROR,  32'h9999, 4'b1101, 3'b101, DA1, DS1, {32'hBAD1BAD1, 32'h0}, 0, 0);
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, DA1, DS1, 0, 0, 1);
        add(0, 2'b00, 2'b00, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, 1);
        // ---- reset in the middle of a SERVE
        add(0, 2'b00, 2'b01, 2'b00, FREE,   0,        4'hF,    3'b000, 0,   0,   0, 0, -1);
        add(0, 2'b00, 2'b01, 2'b00, BUSY,   0,        4'hF,    3'b100, DA0, DS0, 0, 0, -1);
        add(1, 2'b00, 2'b01, 2'b00, BUSY,   0,        4'hF,    3'b100, DA0, DS0, 0, 0, -1);
        add(0, 2'b00, 2'b00, 2'b00, ACCESS, 32'h77,   4'hF,    3'b000, 0,   0,   0, 0, 0);
        add(0, 2'b00, 2'b00, 2'b00, ACCESS, 32'h77,   4'hF,    3'b000, 0,   0,   0, 0, 0);

        @(negedge CLK);
        foreach (vecs[i]) begin
            RST = vecs[i].rst; iREN = vecs[i].iren; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
            ramstate = vecs[i].rs; ramload = vecs[i].rload;
            #1;
            expect_out($sformatf("v%0d", i), vecs[i].e_wait, vecs[i].e_str, vecs[i].e_addr,
                       vecs[i].e_store, vecs[i].e_dl, vecs[i].e_il);
`ifdef MEM_ARBITER_STATS_EN
            if (vecs[i].e_ec >= 0)
                check($sformatf("v%0d err_count", i), 64'(err_count), 64'(vecs[i].e_ec));
`endif
            @(negedge CLK);
        end

        // ---- core0 locked burst: write 0x80, write 0x84 (REN+WEN), read 0x100, read 0x104
        RST = 1'b0; iREN = '0; dREN = '0; dWEN = 2'b01;
        daddr[0] = 32'h80; dstore[0] = 32'hA; ramstate = FREE; ramload = '0;
        #1 expect_out("burst arb", 4'hF, 3'b000, 0, 0, 0, 0);
        @(negedge CLK); ramstate = BUSY;
        #1 expect_out("burst w0 busy", 4'hF, 3'b010, 32'h80, 32'hA, 0, 0);
        @(negedge CLK); ramstate = ACCESS;
        #1 expect_out("burst w0", 4'b1110, 3'b010, 32'h80, 32'hA, 0, 0);
        @(negedge CLK); daddr[0] = 32'h84; dstore[0] = 32'hB; dREN = 2'b01;
        #1 expect_out("burst w1", 4'b1110, 3'b010, 32'h84, 32'hB, 0, 0);
        @(negedge CLK); dWEN = 2'b00; daddr[0] = 32'h100; ramload = 32'hD00D;
        #1 expect_out("burst r0", 4'b1110, 3'b100, 32'h100, 32'hB, 64'hD00D, 0);
        @(negedge CLK); daddr[0] = 32'h104; ramload = 32'hD11D;
        #1 expect_out("burst r1", 4'b1110, 3'b100, 32'h104, 32'hB, 64'hD11D, 0);
        @(negedge CLK); dREN = 2'b00; ramstate = FREE;
        #1 expect_out("burst release", 4'hF, 3'b000, 32'h104, 32'hB, 0, 0);
        @(negedge CLK);
        #1 expect_out("burst idle", 4'hF, 3'b000, 0, 0, 0, 0);
`ifdef MEM_ARBITER_STATS_EN
        check("burst dwords0", 64'(dwords[0]), 64'd4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache_control_if protocol: accepts instruction fetches (iREN) and data reads/writes (dREN/dWEN) from every core's icache and dcache and serialises them onto the single-ported RAM. Holds `iwait`/`dwait` high until the RAM completes each word, then drops them for exactly one cycle with `iload`/`dload` valid. It sits between the per-core caches and the RAM model inside the memory-control hierarchy. It provides the other end of the handshake that dcache bursts (writeback + two-word fetch, flush) depend on.

## Interface
- CPUS, 2, number of cores; each has one icache port and one dcache port
- RAM_ERR_WORD, 32'hBAD1BAD1, value returned on a RAM ERROR completion
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- iREN  in  CPUS  icache read request per core
- iaddr  in  CPUS×32  icache word address
- iwait  out  CPUS  icache wait; low for one cycle when a word completes
- iload  out  CPUS×32  icache read data, valid while iwait low
- dREN, dWEN  in  CPUS each  dcache read/write request
- daddr, dstore  in  CPUS×32 each  dcache address / write data
- dwait  out  CPUS  dcache wait; low for one cycle per completed word
- dload  out  CPUS×32  dcache read data, valid while dwait low
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr, ramstore  out  32 each  RAM address / write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE, BUSY, ACCESS, ERROR (ramstate_t)
- ram_err  out  1  one-cycle pulse on an ERROR completion

## Operation
- States: ARB, SERVE.
- ARB: no RAM strobes asserted. Pick one requester, register it as the grant, go to SERVE. If no requests, stay in ARB.
- Priority: any dcache request (dREN|dWEN) beats any icache request. Within a class, round-robin across cores. The per-class pointer holds the last granted core; on contention, pick the next core after the pointer.
- SERVE: route the granted port's address, data and strobes to the RAM combinationally. If dWEN and dREN are both high, treat the access as a write (ramWEN=1, ramREN=0).
- ramstate == ACCESS: the word is complete. Drop the granted wait for that cycle and drive ramload onto its load (reads only).
- ramstate == ERROR: completion with load = RAM_ERR_WORD and ram_err pulse.
- FREE/BUSY: wait stays high.
- Lock: the grant is held across cycles while the granted requester keeps its REN|WEN high. This covers multi-word bursts and read/write mixes within one grant (writeback → fetch), with a new address taken each cycle.
- Requester drops its strobes: return to ARB next cycle. Loads are don't-care for the dropped word.
- Non-granted ports: wait=1, load=0.
- icache can be starved by continuous dcache traffic; this is accepted.

## Timing
- Reset (RST high at edge): state ARB, grant cleared, pointers = core 0. All iwait/dwait = 1, all loads = 0, ramREN/ramWEN = 0, ramaddr/ramstore = 0, ram_err = 0.
- Reset mid-SERVE aborts the access; no completion pulse is issued.
- Latency:
  - Request is seen in ARB in cycle n; SERVE starts at n+1.
  - Earliest completion is at n+1, if the RAM reports ACCESS the same cycle.
  - Each subsequent burst word completes as soon as the RAM reports ACCESS. No bubble between words of a locked burst.
- Between different grants there is exactly one ARB cycle with RAM strobes low.
- A requester that drops its strobe in the same cycle as its completion gets the completion and releases.

## Configuration
- `MEM_ARBITER_STATS_EN` defined:
  - Add outputs `iwords` and `dwords` (CPUS×32 each), counting completed words per port. Counters wrap at 2^32 and clear on RST.
  - Add `err_count` (16 bits), which saturates at 16'hFFFF.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `cpu_types_pkg` holds `word_t` and `ramstate_t`; add `arb_state_t` (ARB, SERVE) and `arb_src_t` (core index plus I/D flag) there.
- One sub-module, `rr_pick`: a CPUS-wide request vector plus last-grant pointer in, and a one-hot grant plus valid out. It is instantiated twice, once for the D class and once for the I class.

## Test plan
- Core0 dREN @0x40, RAM ACCESS after 2 BUSY cycles, ramload=0x1234 → dwait[0] low for one cycle with dload[0]=0x1234; iwait stays high.
- Core0 iREN and core1 dREN at the same time → core1 granted first; core0 icache is served after core1 drops dREN, following one ARB cycle.
- Both cores dREN continuously for 4 grants → grants alternate 1,0,1,0 starting from the reset pointer.
- Core0 burst: dWEN 0x80 / 0x84 (stores 0xA, 0xB), then dREN 0x100 / 0x104 with the strobe kept high throughout → four completions under one grant, RAM sees the writes in order, no ARB cycle between words.
- ramstate ERROR on a core1 dREN → dload[1]=0xBAD1BAD1, dwait[1] low one cycle, ram_err pulse; with stats enabled, err_count=1.
- RST asserted mid-SERVE → next cycle all waits are 1, ram strobes are 0, state is ARB; the interrupted word gets no completion.
